// File: rtl/qc_link_host.sv
// qc_link_host: host-side driver of the byte/toggle GPIO link into quantumCompFSM.
// Serializes an upstream byte stream (state vector, then gate matrix; real byte
// then imaginary byte per element) onto load_data/load_ready. It then toggles the
// strobe once per readback byte and forwards send_data downstream as a byte stream.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   in_data    in   upstream byte
//   in_valid   in   upstream byte valid
//   in_ready   out  host accepts in_data this cycle (high only while waiting for a load byte)
//   out_data   out  readback byte
//   out_valid  out  readback byte valid
//   out_ready  in   downstream accepts out_data
//   load_data  out  byte presented to the receiver
//   load_ready out  toggle strobe to the receiver (rising = real, falling = imaginary)
//   send_data  in   byte returned by the receiver
//   busy       out  transaction in progress
//   done       out  one-cycle pulse after the final readback byte is accepted
module qc_link_host #(
  parameter int unsigned N      = 2,
  parameter int unsigned HOLD   = 4,
  parameter int unsigned SETTLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] load_data,
  output logic       load_ready,
  input  logic [7:0] send_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX        = 1 << N;
  localparam int unsigned LOAD_BYTES = 2 * MAX + 2 * MAX * MAX;
  localparam int unsigned RB_BYTES   = 2 * MAX;
  localparam int unsigned BW         = $clog2(LOAD_BYTES);
  localparam int unsigned RW         = $clog2(RB_BYTES);
  localparam int unsigned HMAX       = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int unsigned HW         = $clog2(HMAX + 1);

  localparam logic [2:0] LD_WAIT   = 3'd0;
  localparam logic [2:0] LD_SETUP  = 3'd1;
  localparam logic [2:0] LD_HOLD   = 3'd2;
  localparam logic [2:0] SETTLE_ST = 3'd3;
  localparam logic [2:0] RB_TOGGLE = 3'd4;
  localparam logic [2:0] RB_HOLD   = 3'd5;
  localparam logic [2:0] RB_EMIT   = 3'd6;
  localparam logic [2:0] DONE_ST   = 3'd7;

  logic [2:0]    state, state_n;
  logic [BW-1:0] byte_cnt, byte_cnt_n;
  logic [RW-1:0] rb_cnt, rb_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;

  logic       in_ready_n;
  logic [7:0] out_data_n;
  logic       out_valid_n;
  logic [7:0] load_data_n;
  logic       load_ready_n;
  logic       busy_n;
  logic       done_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= LD_WAIT;
      byte_cnt   <= '0;
      rb_cnt     <= '0;
      hold_cnt   <= '0;
      in_ready   <= 1'b1;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      load_data  <= 8'h00;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      rb_cnt     <= rb_cnt_n;
      hold_cnt   <= hold_cnt_n;
      in_ready   <= in_ready_n;
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      load_data  <= load_data_n;
      load_ready <= load_ready_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    rb_cnt_n     = rb_cnt;
    hold_cnt_n   = hold_cnt;
    out_data_n   = out_data;
    out_valid_n  = out_valid;
    load_data_n  = load_data;
    load_ready_n = load_ready;
    busy_n       = busy;
    done_n       = 1'b0;

    case (state)
      LD_WAIT: begin
        if (in_valid && in_ready) begin
          load_data_n = in_data;
          busy_n      = 1'b1;
          state_n     = LD_SETUP;
        end
      end

      // load_data has been stable for this cycle; now flip the strobe
      LD_SETUP: begin
        load_ready_n = ~load_ready;
        hold_cnt_n   = '0;
        state_n      = LD_HOLD;
      end

      LD_HOLD: begin
        if (hold_cnt == HW'(HOLD - 1)) begin
          hold_cnt_n = '0;
          if (byte_cnt == BW'(LOAD_BYTES - 1)) begin
            state_n = SETTLE_ST;
          end else begin
            byte_cnt_n = byte_cnt + BW'(1);
            state_n    = LD_WAIT;
          end
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end

      // Give the receiver's multiplier time before the first readback toggle
      SETTLE_ST: begin
        if (hold_cnt == HW'(SETTLE - 1)) begin
          hold_cnt_n = '0;
          state_n    = RB_TOGGLE;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end

      RB_TOGGLE: begin
        load_ready_n = ~load_ready;
        hold_cnt_n   = '0;
        state_n      = RB_HOLD;
      end

      // Sample the receiver's reply HOLD cycles after the toggle
      RB_HOLD: begin
        if (hold_cnt == HW'(HOLD - 1)) begin
          hold_cnt_n  = '0;
          out_data_n  = send_data;
          out_valid_n = 1'b1;
          state_n     = RB_EMIT;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end

      // Backpressure parks here; strobe and counters stay frozen
      RB_EMIT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (rb_cnt == RW'(RB_BYTES - 1)) begin
            done_n  = 1'b1;
            state_n = DONE_ST;
          end else begin
            rb_cnt_n = rb_cnt + RW'(1);
            state_n  = RB_TOGGLE;
          end
        end
      end

      DONE_ST: begin
        byte_cnt_n = '0;
        rb_cnt_n   = '0;
        hold_cnt_n = '0;
        busy_n     = 1'b0;
        state_n    = LD_WAIT;
      end

      default: begin
        state_n = LD_WAIT;
      end
    endcase

    // Registered ready tracks the state we are entering
    in_ready_n = (state_n == LD_WAIT);
  end

endmodule

// File: tb/tb_qc_link_host.sv
// tb_qc_link_host: directed bench for qc_link_host with a behavioural receiver.
// The receiver records load_data on every load_ready edge and answers readback
// edge 40+k with send_data = 0xA0+k.
`timescale 1ns/1ps
module tb_qc_link_host;

  localparam int HOLD   = 4;
  localparam int BUDGET = 3000;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic [7:0] in_data    = 8'h00;
  logic       in_valid   = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready  = 1'b0;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] send_data  = 8'h00;
  logic       busy;
  logic       done;

  qc_link_host #(.N(2), .HOLD(HOLD), .SETTLE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .load_data  (load_data),
    .load_ready (load_ready),
    .send_data  (send_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reset as seen by the DUT at the last rising edge
  logic rst_q = 1'b0;
  always @(posedge clk) rst_q <= reset;

  int n_cmp = 0;
  int n_bad = 0;

  int edges, since_tog, nacc, nout, ndone, hs8_tick, done_tick, tick_no;
  logic       prev_lr;
  logic [7:0] prev_ld;
  logic [7:0] rx [0:39];
  logic [7:0] ox [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: note handshakes due at the rising edge, then observe at the falling edge
  task automatic tick();
    logic       hs, ihs;
    logic [7:0] hd, idd;
    hs  = out_valid && out_ready && reset;
    hd  = out_data;
    ihs = in_valid && in_ready && reset;
    idd = in_data;
    @(negedge clk);
    tick_no++;
    if (!rst_q) begin
      edges     = 0;
      since_tog = 100;
      prev_lr   = load_ready;
      prev_ld   = load_data;
    end else begin
      if (ihs) begin
        if (nacc < 40) rx[nacc] = idd;
        nacc++;
      end
      if (hs) begin
        if (nout < 8) ox[nout] = hd;
        nout++;
        if (nout == 8) hs8_tick = tick_no;
      end
      if (done) begin
        ndone++;
        done_tick = tick_no;
      end
      since_tog++;
      if (load_data !== prev_ld)
        check("ld_hold_after_edge", 32'(since_tog > HOLD), 32'd1);
      if (load_ready !== prev_lr) begin
        edges++;
        check("ld_setup_before_edge", 32'(load_data), 32'(prev_ld));
        check("edge_polarity", 32'(load_ready), 32'(edges % 2));
        since_tog = 0;
        if (edges > 40) send_data = 8'hA0 + 8'(edges - 40);
      end
      prev_lr = load_ready;
      prev_ld = load_data;
    end
  endtask

  task automatic run_txn(input logic [7:0] base, input bit gaps, input bit bp);
    int cyc;
    int bp_cnt;
    bit fin;
    edges = 0; nacc = 0; nout = 0; ndone = 0;
    hs8_tick = -1; done_tick = -2;
    cyc = 0; bp_cnt = 0; fin = 1'b0;
    while (!fin && cyc < BUDGET) begin
      in_valid = gaps ? (((cyc / 3) % 2) == 0) : 1'b1;
      in_data  = (nacc < 40) ? base + 8'(nacc) : 8'hEE;
      if (bp && nout == 2 && out_valid && bp_cnt < 10) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        if (bp && bp_cnt == 10) begin
          check("bp_out_valid",  32'(out_valid),  32'd1);
          check("bp_out_data",   32'(out_data),   32'hA3);
          check("bp_load_ready", 32'(load_ready), 32'd1);
          check("bp_edges",      32'(edges),      32'd43);
          bp_cnt = 11;
        end
        out_ready = 1'b1;
      end
      if (edges == 40 && since_tog == HOLD + 2)
        check("settle_in_ready", 32'(in_ready), 32'd0);
      tick();
      cyc++;
      if (done) fin = 1'b1;
    end
    check("txn_finished", 32'(fin), 32'd1);
  endtask

  task automatic check_txn(input logic [7:0] base);
    int bad;
    check("load_count", 32'(nacc),  32'd40);
    check("edge_count", 32'(edges), 32'd48);
    check("state0_re",  32'(rx[0]),  32'(base + 8'd0));
    check("state0_im",  32'(rx[1]),  32'(base + 8'd1));
    check("state3_re",  32'(rx[6]),  32'(base + 8'd6));
    check("state3_im",  32'(rx[7]),  32'(base + 8'd7));
    check("gate00_re",  32'(rx[8]),  32'(base + 8'd8));
    check("gate00_im",  32'(rx[9]),  32'(base + 8'd9));
    check("gate33_re",  32'(rx[38]), 32'(base + 8'd38));
    check("gate33_im",  32'(rx[39]), 32'(base + 8'd39));
    bad = 0;
    for (int i = 0; i < 40; i++) if (rx[i] !== base + 8'(i)) bad++;
    check("load_stream_all", 32'(bad), 32'd0);
    check("rb_count", 32'(nout), 32'd8);
    for (int i = 0; i < 8; i++) check("rb_byte", 32'(ox[i]), 32'(8'hA1 + 8'(i)));
    check("done_count", 32'(ndone), 32'd1);
    check("done_timing", 32'(done_tick), 32'(hs8_tick));
  endtask

  task automatic idle_checks();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("idle_done",       32'(done),       32'd0);
    check("idle_busy",       32'(busy),       32'd0);
    check("idle_load_ready", 32'(load_ready), 32'd0);
    check("idle_in_ready",   32'(in_ready),   32'd1);
    check("idle_out_valid",  32'(out_valid),  32'd0);
  endtask

  initial begin
    int cyc;
    edges = 0; since_tog = 100; nacc = 0; nout = 0; ndone = 0;
    hs8_tick = -1; done_tick = -2; tick_no = 0;
    prev_lr = 1'b0; prev_ld = 8'h00;

    // Reset values
    reset = 1'b0;
    repeat (3) tick();
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_data",  32'(load_data),  32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    reset = 1'b1;

    // Continuous stream with backpressure on readback byte 0xA3
    run_txn(8'h01, 1'b0, 1'b1);
    check_txn(8'h01);
    idle_checks();

    // Upstream gaps every 3 cycles
    run_txn(8'h01, 1'b1, 1'b0);
    check_txn(8'h01);
    idle_checks();

    // Reset after load byte 17 has been strobed
    edges = 0; nacc = 0; nout = 0; ndone = 0; cyc = 0;
    while (edges < 17 && cyc < BUDGET) begin
      in_valid  = 1'b1;
      in_data   = 8'h01 + 8'(nacc);
      out_ready = 1'b1;
      tick();
      cyc++;
    end
    check("abort_edges", 32'(edges), 32'd17);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_load_ready", 32'(load_ready), 32'd0);
    check("abort_in_ready",   32'(in_ready),   32'd1);
    check("abort_busy",       32'(busy),       32'd0);
    check("abort_out_valid",  32'(out_valid),  32'd0);
    check("abort_load_data",  32'(load_data),  32'd0);
    run_txn(8'h01, 1'b0, 1'b0);
    check_txn(8'h01);
    idle_checks();

    // Back-to-back transactions with no idle between
    run_txn(8'h31, 1'b0, 1'b0);
    check_txn(8'h31);
    run_txn(8'h61, 1'b0, 1'b0);
    check_txn(8'h61);
    idle_checks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
